// File: rtl/main_pkg.sv
`default_nettype none
// ============================================================================
// Module      : main_pkg
// Description : Shared constants for the register-file / ALU datapath:
//               ALU opcodes, register count, data width and index width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package main_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int IDX_W    = 5;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/main_regfile.sv
`default_nettype none
// ============================================================================
// Module      : main_regfile
// Description : 32 x 32-bit register file, two combinational read ports,
//               one synchronous write port, asynchronous active-low clear.
//               Register 0 is hard-wired to zero.
// Ports       : clk    - write clock (rising edge)
//               rst_n  - asynchronous active-low clear of all registers
//               i_ra   - read port A index     o_a - read port A data
//               i_rb   - read port B index     o_b - read port B data
//               i_rw   - write index           i_we - write enable
//               i_wd   - write data
// Revision    : 1.0 - initial release
// ============================================================================
module main_regfile
    import main_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  i_ra,
    input  logic [IDX_W-1:0]  i_rb,
    input  logic [IDX_W-1:0]  i_rw,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wd,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_b
);

    logic [DATA_W-1:0] w_regs [NUM_REGS];

    // r0 has no storage; it always reads zero and ignores writes.
    assign w_regs[0] = '0;

    generate
        for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
            logic [DATA_W-1:0] r_q;
            logic              w_sel;

            assign w_sel = i_we && (i_rw == IDX_W'(i));

            // Asynchronous clear also wins over a write on the same edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (w_sel) begin
                    r_q <= i_wd;
                end
            end

            assign w_regs[i] = r_q;
        end
    endgenerate

    // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
    assign o_a = w_regs[i_ra];
    assign o_b = w_regs[i_rb];

endmodule
`default_nettype wire

// File: rtl/main.sv
`default_nettype none
// ============================================================================
// Module      : main
// Description : Register file + 2-operand ALU datapath. Operands are read
//               combinationally, the ALU result drives the zero and
//               signed-overflow flags, and the write-back value is either
//               external data or the ALU result.
// Ports       : clk0  - system clock (rising edge)
//               clrn0 - asynchronous active-low reset
//               ra0   - operand A register index
//               rb0   - operand B register index
//               rw0   - destination register index
//               we0   - write enable
//               rd0   - external write data
//               s0    - write-data select (0: rd0, 1: ALU result)
//               aluc0 - ALU op (0 add, 1 sub, 2 and, 3 or)
//               z0    - ALU result is zero (combinational)
//               v0    - ALU signed overflow (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module main
    import main_pkg::*;
(
    input  logic              clk0,
    input  logic              clrn0,
    input  logic [IDX_W-1:0]  ra0,
    input  logic [IDX_W-1:0]  rb0,
    input  logic [IDX_W-1:0]  rw0,
    input  logic              we0,
    input  logic [DATA_W-1:0] rd0,
    input  logic              s0,
    input  logic [1:0]        aluc0,
    output logic              z0,
    output logic              v0
);

    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_wd;

    main_regfile u_regfile (
        .clk   (clk0),
        .rst_n (clrn0),
        .i_ra  (ra0),
        .i_rb  (rb0),
        .i_rw  (rw0),
        .i_we  (we0),
        .i_wd  (w_wd),
        .o_a   (w_a),
        .o_b   (w_b)
    );

    always_comb begin
        w_alu = '0;
        v0    = 1'b0;
        case (aluc0)
            ALU_ADD: begin
                w_alu = w_a + w_b;
                v0    = (w_a[DATA_W-1] == w_b[DATA_W-1]) &&
                        (w_alu[DATA_W-1] != w_a[DATA_W-1]);
            end
            ALU_SUB: begin
                w_alu = w_a - w_b;
                v0    = (w_a[DATA_W-1] != w_b[DATA_W-1]) &&
                        (w_alu[DATA_W-1] != w_a[DATA_W-1]);
            end
            ALU_AND: w_alu = w_a & w_b;
            default: w_alu = w_a | w_b;
        endcase
    end

    assign z0   = (w_alu == '0);

    // Write-back data comes from the pre-edge operands, so reading and
    // writing the same register forms no loop.
    assign w_wd = s0 ? w_alu : rd0;

endmodule
`default_nettype wire

// File: tb/tb_main.sv
`default_nettype none
// ============================================================================
// Module      : tb_main
// Description : Self-checking bench for main. Stimulus pushes the expected
//               {z0,v0} pair into a queue; a monitor pops and compares on the
//               falling clock edge. Register contents are observed through
//               the ALU by subtracting against scratch registers r30/r31.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main;

    logic        clk0;
    logic        clrn0;
    logic [4:0]  ra0;
    logic [4:0]  rb0;
    logic [4:0]  rw0;
    logic        we0;
    logic [31:0] rd0;
    logic        s0;
    logic [1:0]  aluc0;
    logic        z0;
    logic        v0;

    main dut (
        .clk0  (clk0),
        .clrn0 (clrn0),
        .ra0   (ra0),
        .rb0   (rb0),
        .rw0   (rw0),
        .we0   (we0),
        .rd0   (rd0),
        .s0    (s0),
        .aluc0 (aluc0),
        .z0    (z0),
        .v0    (v0)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    logic [1:0] q_exp  [$];
    string      q_name [$];
    int         n_checks = 0;
    int         n_fails  = 0;

    // Monitor: flags are combinational, so compare mid-cycle when inputs
    // have settled and before the next write edge.
    always @(negedge clk0) begin
        if (q_exp.size() > 0) begin
            logic [1:0] e;
            string      nm;
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            n_checks++;
            if ({z0, v0} !== e) begin
                n_fails++;
                $display("FAIL %s: {z0,v0} actual=%b required=%b", nm, {z0, v0}, e);
            end
        end
    end

    // Apply one cycle of inputs (called just after a rising edge) and
    // optionally queue the flags expected before the next edge.
    task automatic drive(input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] w, input logic we,
                         input logic [31:0] d, input logic s,
                         input logic [1:0] op, input bit chk,
                         input logic ez, input logic ev, input string nm);
        ra0 = a; rb0 = b; rw0 = w; we0 = we; rd0 = d; s0 = s; aluc0 = op;
        if (chk) begin
            q_exp.push_back({ez, ev});
            q_name.push_back(nm);
        end
        @(posedge clk0);
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] val);
        drive(5'd0, 5'd0, idx, 1'b1, val, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, "");
    endtask

    // r[idx]==k  <=>  r[idx]-k == 0 and r[idx]-(k+1) != 0
    task automatic chk_reg(input logic [4:0] idx, input logic [31:0] k, input string nm);
        wr(5'd31, k);
        wr(5'd30, k + 32'd1);
        drive(idx, 5'd31, 5'd0, 1'b0, 32'd0, 1'b0, OP_SUB, 1'b1, 1'b1, 1'b0, {nm, "_eq"});
        drive(idx, 5'd30, 5'd0, 1'b0, 32'd0, 1'b0, OP_SUB, 1'b1, 1'b0, 1'b0, {nm, "_ne"});
    endtask

    initial begin
        clrn0 = 1'b0;
        ra0 = 5'd1; rb0 = 5'd2; rw0 = 5'd0; we0 = 1'b1; rd0 = 32'd9; s0 = 1'b0; aluc0 = OP_ADD;
        repeat (2) @(posedge clk0);
        #1;
        // Reset state, with a write request held off by reset.
        drive(5'd1, 5'd2, 5'd1, 1'b1, 32'd9, 1'b0, OP_ADD, 1'b1, 1'b1, 1'b0, "reset_flags");
        clrn0 = 1'b1;

        // Scenario 1: r1=5, r2=4, r3 = r1 - r2
        wr(5'd1, 32'd5);
        wr(5'd2, 32'd4);
        drive(5'd1, 5'd2, 5'd3, 1'b1, 32'd0, 1'b1, OP_SUB, 1'b1, 1'b0, 1'b0, "s1_sub_flags");
        chk_reg(5'd3, 32'd1, "s1_r3");
        // Read-modify-write of the same register: r3 = r3 + r3 from old value
        drive(5'd3, 5'd3, 5'd3, 1'b1, 32'd0, 1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, "rmw_flags");
        chk_reg(5'd3, 32'd2, "rmw_r3");

        // Scenario 2
        wr(5'd4, 32'd66);
        wr(5'd5, 32'd21);
        drive(5'd4, 5'd5, 5'd6, 1'b1, 32'd0, 1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, "s2_add_flags");
        chk_reg(5'd6, 32'd87, "s2_r6");
        wr(5'd7, 32'd33);
        wr(5'd8, 32'd11);
        drive(5'd7, 5'd8, 5'd9, 1'b1, 32'd0, 1'b1, OP_AND, 1'b1, 1'b0, 1'b0, "s2_and_flags");
        chk_reg(5'd9, 32'd1, "s2_r9");

        // Scenario 3
        wr(5'd10, 32'd18);
        wr(5'd11, 32'd8);
        drive(5'd10, 5'd11, 5'd12, 1'b1, 32'd0, 1'b1, OP_OR, 1'b1, 1'b0, 1'b0, "s3_or_flags");
        chk_reg(5'd12, 32'd26, "s3_r12");

        // Scenario 4: overflow and zero boundaries
        wr(5'd14, 32'h7FFF_FFFF);
        wr(5'd15, 32'd1);
        wr(5'd16, 32'h8000_0000);
        wr(5'd17, 32'd5);
        drive(5'd14, 5'd15, 5'd18, 1'b1, 32'd0, 1'b1, OP_ADD, 1'b1, 1'b0, 1'b1, "s4_add_ovf");
        chk_reg(5'd18, 32'h8000_0000, "s4_r18");
        drive(5'd16, 5'd15, 5'd0, 1'b0, 32'd0, 1'b0, OP_SUB, 1'b1, 1'b0, 1'b1, "s4_sub_ovf");
        drive(5'd17, 5'd17, 5'd0, 1'b0, 32'd0, 1'b0, OP_SUB, 1'b1, 1'b1, 1'b0, "s4_sub_zero");
        drive(5'd14, 5'd16, 5'd0, 1'b0, 32'd0, 1'b0, OP_AND, 1'b1, 1'b1, 1'b0, "s4_and_zero");
        drive(5'd14, 5'd16, 5'd0, 1'b0, 32'd0, 1'b0, OP_OR,  1'b1, 1'b0, 1'b0, "s4_or_noovf");

        // Scenario 5: r0 write ignored, we0=0 holds
        wr(5'd0, 32'd99);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0, OP_OR, 1'b1, 1'b1, 1'b0, "s5_r0_zero");
        wr(5'd13, 32'd3);
        drive(5'd0, 5'd0, 5'd13, 1'b0, 32'd7, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, "");
        chk_reg(5'd13, 32'd3, "s5_r13");

        // Scenario 6: asynchronous reset between edges
        drive(5'd1, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0, "s6_pre_reset");
        ra0 = 5'd1; rb0 = 5'd0; rw0 = 5'd20; we0 = 1'b1; rd0 = 32'd55; s0 = 1'b0; aluc0 = OP_ADD;
        #1;
        clrn0 = 1'b0;
        q_exp.push_back(2'b10);
        q_name.push_back("s6_async_clear");
        @(posedge clk0);
        #1;
        clrn0 = 1'b1;
        chk_reg(5'd20, 32'd0, "s6_r20_discard");
        chk_reg(5'd1, 32'd0, "s6_r1_cleared");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(posedge clk0);
        if (q_exp.size() > 0) begin
            n_fails++;
            $display("FAIL drain: pending=%0d required=0", q_exp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 The block SHALL have port clk0, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port clrn0, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port ra0, input, 5 bits: register index for ALU operand A (read port A).
REQ-004 The block SHALL have port rb0, input, 5 bits: register index for ALU operand B (read port B).
REQ-005 The block SHALL have port rw0, input, 5 bits: destination register index for the write port.
REQ-006 The block SHALL have port we0, input, 1 bit: write enable, active high.
REQ-007 The block SHALL have port rd0, input, 32 bits: external write data.
REQ-008 The block SHALL have port s0, input, 1 bit: write-data select; 0 selects rd0, 1 selects the ALU result.
REQ-009 The block SHALL have port aluc0, input, 2 bits: ALU operation select.
REQ-010 The block SHALL have port z0, output, 1 bit: zero flag of the current ALU result.
REQ-011 The block SHALL have port v0, output, 1 bit: signed-overflow flag of the current ALU result.
REQ-012 There SHALL be one clock (clk0); reset (clrn0) is asynchronous and active-low.

Function
REQ-013 The block SHALL contain 32 registers of 32 bits each, r0..r31.
REQ-014 Reads SHALL be combinational: A = r[ra0], B = r[rb0], with zero cycles of latency.
REQ-015 r0 SHALL always read 0, and writes to r0 SHALL be ignored.
REQ-016 On the rising edge of clk0, when we0=1 and rw0!=0, r[rw0] SHALL be loaded with W, where W = s0 ? ALU result : rd0.
REQ-017 When we0=0, no register SHALL change.
REQ-018 A read of register rw0 in the same cycle as a write to it SHALL return the old value; the new value SHALL be visible only after the edge.
REQ-019 A read and write of the same register (e.g. ra0=rw0 with s0=1) SHALL compute from the old value and store the result at the edge; there is no combinational loop.
REQ-020 ALU operation by aluc0 SHALL be:
- 0: A+B
- 1: A-B
- 2: A AND B
- 3: A OR B
Arithmetic is 32-bit modulo 2^32.
REQ-021 z0 SHALL be 1 exactly when the 32-bit ALU result is 0, independent of s0 and we0.
REQ-022 v0 SHALL be the two's-complement overflow flag:
- add: A[31]==B[31] and R[31]!=A[31]
- sub: A[31]!=B[31] and R[31]!=A[31]
- AND/OR: 0
REQ-023 z0 and v0 SHALL be purely combinational and unregistered.

Reset
REQ-024 While clrn0=0, all registers SHALL be 0, asynchronously, regardless of clk0 or we0.
REQ-025 A write on the same edge on which reset is asserted SHALL be discarded.
REQ-026 Consequently, after reset with aluc0=0, z0=1 and v0=0.
REQ-027 After clrn0 deasserts, the first rising edge of clk0 SHALL perform normal writes.

Structure
REQ-028 A shared package main_pkg SHALL define:
- ALU opcode constants ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3
- register count 32
- data width 32
- index width 5
REQ-029 The register file SHALL be a single sub-module main_regfile with 2 read ports, 1 write port and async clear.
REQ-030 The ALU, write-data mux and flag logic SHALL be in main.

Verification
REQ-031 Scenario 1: write r1=5 and r2=4 (s0=0, we0=1) -> then ra0=1, rb0=2, aluc0=1, s0=1, rw0=3 -> before the edge z0=0, v0=0; r3=1 after the edge.
REQ-032 Scenario 2: r4=66, r5=21, aluc0=0, rw0=6 -> r6=87, z0=0; r7=33, r8=11, aluc0=2, rw0=9 -> r9=1.
REQ-033 Scenario 3: r10=18, r11=8, aluc0=3, rw0=12 -> r12=26.
REQ-034 Scenario 4: A=0x7FFFFFFF, B=1, add -> result 0x80000000, v0=1; A=0x80000000, B=1, sub -> v0=1; A=5, B=5, sub -> z0=1, v0=0.
REQ-035 Scenario 5: write 99 to r0 -> r0 reads 0; we0=0 with rd0=7 to r13 -> r13 unchanged.
REQ-036 Scenario 6: pulse clrn0 low mid-sequence between edges -> all registers read 0 immediately; a write requested at that edge is not stored.
